aes128_iter_core: RTL and testbench

- Parametrised iterative AES-128 encryption core (FIPS-197), successor to the fixed-latency `aes_top`.
- Adds a valid/ready handshake on both input and output, output backpressure with hold, and a configurable number of rounds per clock (area/latency trade-off).
- Keys are expanded on the fly, one round key per round, with no stored key schedule.
- Sits between the block-cipher mode logic upstream and the ciphertext sink downstream.

---
 rtl/aes128_iter_core_if.sv | 21 ++
 rtl/aes128_iter_core.sv | 184 ++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_iter_core_if.sv
// Block-in / ciphertext-out handshake bundle for aes128_iter_core.
interface aes128_iter_core_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;
   logic         busy;

   modport master (
      output in_valid, data_in, key_in, out_ready,
      input  in_ready, out_valid, data_out, busy
   );

   modport slave (
      input  in_valid, data_in, key_in, out_ready,
      output in_ready, out_valid, data_out, busy
   );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE unrolled rounds per clock,
// round keys expanded on the fly, valid/ready with hold on both sides.
module aes128_iter_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              reset,
   aes128_iter_core_if.slave bus
);

   localparam int R = ROUNDS_PER_CYCLE;

   generate
      if (R != 1 && R != 2 && R != 5 && R != 10) begin : g_bad_rounds
         $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
      end
   endgenerate

   // Byte 0x00 sits in the top byte of this flattened table.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_DONE
   } state_t;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[2047 - 8 * int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rn);
      case (rn)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // SubBytes and ShiftRows fused: byte (row r, col c) = 127-8*(4c+r).
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32 * c -: 8];
         a1 = s[119 - 32 * c -: 8];
         a2 = s[111 - 32 * c -: 8];
         a3 = s[103 - 32 * c -: 8];
         o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   state_t       r_state;
   logic [3:0]   r_rnd;
   logic [127:0] r_data;
   logic [127:0] r_key;
   logic [127:0] r_dout;

   state_t       w_state_nxt;
   logic         w_in_ready;
   logic         w_accept;
   logic         w_last;
   logic [3:0]   w_rnd_i;
   logic [127:0] w_round_data;
   logic [127:0] w_round_key;

   // NOTE: every always_comb output is given a default first, so no path can infer a latch.
   always_comb begin
      w_round_data = r_data;
      w_round_key  = r_key;
      w_rnd_i      = r_rnd;
      for (int i = 0; i < R; i++) begin
         w_rnd_i      = r_rnd + 4'(i);
         w_round_key  = key_next(w_round_key, rcon(w_rnd_i));
         w_round_data = sub_shift(w_round_data);
         if (w_rnd_i != 4'd10) w_round_data = mix_cols(w_round_data);
         w_round_data = w_round_data ^ w_round_key;
      end
   end

   assign w_last = (r_rnd == 4'(11 - R));

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = S_ROUND;
         end
         S_ROUND: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_in_ready = bus.out_ready;
            if (bus.out_ready) w_state_nxt = bus.in_valid ? S_ROUND : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = w_in_ready & bus.in_valid;

   // NOTE: registers use <= so every flop samples the values from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rnd  <= '0;
         r_data <= '0;
         r_key  <= '0;
         r_dout <= '0;
      end else if (w_accept) begin
         r_data <= bus.data_in ^ bus.key_in;
         r_key  <= bus.key_in;
         r_rnd  <= 4'd1;
      end else if (r_state == S_ROUND) begin
         r_data <= w_round_data;
         r_key  <= w_round_key;
         if (w_last) begin
            r_rnd  <= 4'd10;
            r_dout <= w_round_data;
         end else begin
            r_rnd  <= r_rnd + 4'(R);
         end
      end
   end

   assign bus.in_ready  = w_in_ready & ~reset;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.data_out  = r_dout;
   assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: one instance per legal ROUNDS_PER_CYCLE, all fed
// the same stimulus, checked against a byte-array AES model with a derived S-box.
module tb_aes128_iter_core;

   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] data_in;
   logic [127:0] key_in;

   logic [3:0]   ov;
   logic [3:0]   ir;
   logic [3:0]   bz;
   logic [127:0] dq [4];

   int rpc [4] = '{1, 2, 5, 10};
   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] sb [256];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int RG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
      aes128_iter_core_if bus ();
      aes128_iter_core #(.ROUNDS_PER_CYCLE(RG)) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
      assign bus.in_valid  = in_valid;
      assign bus.data_in   = data_in;
      assign bus.key_in    = key_in;
      assign bus.out_ready = out_ready;
      assign ov[g] = bus.out_valid;
      assign ir[g] = bus.in_ready;
      assign bz[g] = bus.busy;
      assign dq[g] = bus.data_out;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
      return (v << k) | (v >> (8 - k));
   endfunction

   // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   rk [176];
      logic [7:0]   st [16];
      logic [7:0]   tmp [16];
      logic [7:0]   t [4];
      logic [7:0]   a [4];
      logic [7:0]   b0;
      logic [7:0]   rc;
      logic [127:0] ct;
      for (int i = 0; i < 16; i++) rk[i] = key[127 - 8 * i -: 8];
      rc = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) t[j] = rk[i - 4 + j];
         if (i % 16 == 0) begin
            b0   = t[0];
            t[0] = sb[t[1]] ^ rc;
            t[1] = sb[t[2]];
            t[2] = sb[t[3]];
            t[3] = sb[b0];
            rc   = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) rk[i + j] = rk[i - 16 + j] ^ t[j];
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127 - 8 * i -: 8] ^ rk[i];
      for (int rn = 1; rn <= 10; rn++) begin
         for (int i = 0; i < 16; i++) tmp[i] = sb[st[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r + 4 * c] = tmp[r + 4 * ((c + r) % 4)];
         if (rn < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = st[r + 4 * c];
               for (int r = 0; r < 4; r++)
                  st[r + 4 * c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r + 1) % 4])
                                  ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16 * rn + i];
      end
      ct = '0;
      for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = st[i];
      return ct;
   endfunction

   task automatic apply_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      tick();
   endtask

   // One block into all four cores; inputs scrambled every cycle after the accept.
   task automatic run_block(input logic [127:0] d, input logic [127:0] k,
                            input logic [127:0] exp, input string tag);
      int           lat [4];
      logic [127:0] got [4];
      for (int j = 0; j < 4; j++) begin
         lat[j] = 0;
         got[j] = '0;
      end
      in_valid = 1'b0;
      for (int w = 0; w < 20 && ir != 4'hf; w++) tick();
      check({tag, "_ready"}, 128'(ir), 128'hf);
      data_in  = d;
      key_in   = k;
      in_valid = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         tick();
         in_valid = 1'b0;
         data_in  = {$urandom, $urandom, $urandom, $urandom};
         key_in   = {$urandom, $urandom, $urandom, $urandom};
         for (int j = 0; j < 4; j++) begin
            if (ov[j] && lat[j] == 0) begin
               lat[j] = n;
               got[j] = dq[j];
            end
         end
      end
      for (int j = 0; j < 4; j++) begin
         check($sformatf("%s_R%0d_data", tag, rpc[j]), got[j], exp);
         check($sformatf("%s_R%0d_latency", tag, rpc[j]), 128'(lat[j]), 128'(1 + 10 / rpc[j]));
      end
   endtask

   initial begin
      logic [127:0] pt, key, d1, d2;
      int           n1, n2, lat, seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = '0;
      key_in    = '0;
      build_sbox();

      #3;
      check("rst_in_ready", 128'(ir[0]), 128'h0);
      check("rst_out_valid", 128'(ov[0]), 128'h0);
      check("rst_busy", 128'(bz[0]), 128'h0);
      check("rst_data_out", dq[0], 128'h0);
      @(posedge clk);
      #3 reset = 1'b0;
      tick();
      check("post_rst_in_ready", 128'(ir), 128'hf);
      check("post_rst_busy", 128'(bz), 128'h0);

      run_block(C1_PT, C1_KEY, C1_CT, "fips_c1");
      run_block(B_PT, B_KEY, B_CT, "fips_b");

      for (int i = 0; i < 6; i++) begin
         pt  = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         run_block(pt, key, aes_ref(pt, key), $sformatf("rand%0d", i));
      end

      // Backpressure: sink stalls for 7 cycles once ciphertext is presented.
      apply_reset();
      out_ready = 1'b0;
      data_in   = '0;
      key_in    = '0;
      in_valid  = 1'b1;
      lat       = 0;
      for (int n = 1; n <= 15 && lat == 0; n++) begin
         tick();
         in_valid = 1'b0;
         if (ov[0]) lat = n;
      end
      check("bp_latency", 128'(lat), 128'd11);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("bp_hold%0d_out_valid", i), 128'(ov[0]), 128'h1);
         check($sformatf("bp_hold%0d_data", i), dq[0], Z_CT);
         check($sformatf("bp_hold%0d_in_ready", i), 128'(ir[0]), 128'h0);
         if (i < 6) tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 128'(ir[0]), 128'h1);
      tick();
      check("bp_after_handshake_out_valid", 128'(ov[0]), 128'h0);
      check("bp_after_handshake_busy", 128'(bz[0]), 128'h0);

      // Back-to-back streaming with in_valid and out_ready held high.
      apply_reset();
      data_in  = C1_PT;
      key_in   = C1_KEY;
      in_valid = 1'b1;
      n1 = 0;
      n2 = 0;
      d1 = '0;
      d2 = '0;
      for (int n = 1; n <= 30 && n2 == 0; n++) begin
         tick();
         if (n == 1) begin
            data_in = B_PT;
            key_in  = B_KEY;
         end
         if (ov[0]) begin
            if (n1 == 0) begin
               n1 = n;
               d1 = dq[0];
            end else begin
               n2 = n;
               d2 = dq[0];
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      check("b2b_first_latency", 128'(n1), 128'd11);
      check("b2b_gap", 128'(n2 - n1), 128'd11);
      check("b2b_first_data", d1, C1_CT);
      check("b2b_second_data", d2, B_CT);

      // Asynchronous reset while round 5 is being evaluated.
      apply_reset();
      data_in  = C1_PT;
      key_in   = C1_KEY;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      check("abort_busy_before", 128'(bz[0]), 128'h1);
      #3 reset = 1'b1;
      #1;
      check("abort_in_ready", 128'(ir[0]), 128'h0);
      check("abort_out_valid", 128'(ov[0]), 128'h0);
      check("abort_busy", 128'(bz[0]), 128'h0);
      check("abort_data_out", dq[0], 128'h0);
      @(posedge clk);
      #3 reset = 1'b0;
      seen = 0;
      for (int n = 0; n < 15; n++) begin
         tick();
         if (ov[0]) seen++;
      end
      check("abort_no_out_valid", 128'(seen), 128'h0);
      run_block(C1_PT, C1_KEY, C1_CT, "after_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
